// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit
//   Execute-stage unit fed by the ALU control decode (MULTU, SLL, sel).
//   It runs an iterative unsigned WIDTH x WIDTH multiply into the HI/LO
//   registers and performs the SLL shift. It also selects the EX result
//   from the ALU, HI, LO or the shifter. While a multiply is in flight it
//   raises a stall for MFHI/MFLO reads.
//
//   Build option: define MULTU_RADIX4_EN to retire 2 multiplier bits per
//   RUN cycle (WIDTH/2 RUN cycles). The default is radix-2 (WIDTH RUN
//   cycles). WIDTH must be even when MULTU_RADIX4_EN is defined.
//
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     MULTU, SLL, sel   decode controls (sel: 00 ALU, 01 HI, 10 LO, 11 shift)
//     src_a, src_b      multiplicand / multiplier (src_b is also the SLL source)
//     shamt, alu_result SLL amount, ALU output
//     dataOut           selected EX result
//     hi, lo            HI/LO registers
//     busy, done        multiply in progress / one-cycle completion pulse
//     stall             hazard request to the pipeline
module multu_hilo_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MULTU,
   input  logic             SLL,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [4:0]       shamt,
   input  logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] dataOut,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

`ifdef MULTU_RADIX4_EN
   localparam int STEPS = WIDTH / 2;
`else
   localparam int STEPS = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // One shift-add step of the product register.
   logic [2*WIDTH-1:0] prod_step;

`ifdef MULTU_RADIX4_EN
   // Two extra bits on the upper sum: 3*mcand plus the upper half can
   // reach WIDTH+2 bits before the right shift by 2.
   logic [WIDTH+1:0] addend;
   logic [WIDTH+1:0] upper_sum;
   always_comb begin
      addend = '0;
      case (prod_q[1:0])
         2'd0:    addend = '0;
         2'd1:    addend = {2'b00, mcand_q};
         2'd2:    addend = {1'b0, mcand_q, 1'b0};
         default: addend = {2'b00, mcand_q} + {1'b0, mcand_q, 1'b0};
      endcase
      upper_sum = {2'b00, prod_q[2*WIDTH-1:WIDTH]} + addend;
      prod_step = {upper_sum, prod_q[WIDTH-1:2]};
   end
`else
   // The carry out of the add is kept as bit WIDTH and shifts into the top.
   logic [WIDTH:0] upper_sum;
   always_comb begin
      upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_step = {upper_sum, prod_q[WIDTH-1:1]};
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (MULTU) begin
               mcand_d = src_a;
               prod_d  = {{WIDTH{1'b0}}, src_b};
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            prod_d = prod_step;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               hi_d    = prod_step[2*WIDTH-1:WIDTH];
               lo_d    = prod_step[WIDTH-1:0];
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         prod_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   // HI/LO are already written in DONE, so reads do not stall there.
   assign stall = busy & ((sel == 2'b01) | (sel == 2'b10));

   always_comb begin
      dataOut = alu_result;
      case (sel)
         2'b00:   dataOut = alu_result;
         2'b01:   dataOut = hi_q;
         2'b10:   dataOut = lo_q;
         default: dataOut = SLL ? (src_b << shamt) : '0;
      endcase
   end

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;
   localparam int W = 32;
`ifdef MULTU_RADIX4_EN
   localparam int LAT = 16;
`else
   localparam int LAT = 32;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic MULTU = 1'b0, SLL = 1'b0;
   logic [1:0] sel = 2'b00;
   logic [W-1:0] src_a = '0, src_b = '0, alu_result = '0;
   logic [4:0] shamt = '0;
   logic [W-1:0] dataOut, hi, lo;
   logic busy, done, stall;

   multu_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .MULTU(MULTU), .SLL(SLL), .sel(sel),
      .src_a(src_a), .src_b(src_b), .shamt(shamt), .alu_result(alu_result),
      .dataOut(dataOut), .hi(hi), .lo(lo), .busy(busy), .done(done),
      .stall(stall));

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   bit chk_en  = 1'b0;

   // Behavioural model: a multiply is "a*b ready after LAT busy cycles".
   int          m_left = 0;
   logic [63:0] m_prod = '0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   bit          m_done = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_prod = '0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_hi = m_prod[63:32];
            m_lo = m_prod[31:0];
            m_done = 1'b1;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (MULTU) begin
         m_prod = 64'(src_a) * 64'(src_b);
         m_left = LAT;
      end
      chk_en = 1'b1;
   end

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [W-1:0] e_out;
         logic e_busy;
         e_busy = (m_left > 0);
         case (sel)
            2'b00:   e_out = alu_result;
            2'b01:   e_out = m_hi;
            2'b10:   e_out = m_lo;
            default: e_out = SLL ? (src_b << shamt) : '0;
         endcase
         chk("dataOut", dataOut, e_out);
         chk("hi", hi, m_hi);
         chk("lo", lo, m_lo);
         chk("busy", W'(busy), W'(e_busy));
         chk("done", W'(done), W'(m_done));
         chk("stall", W'(stall), W'(e_busy && (sel == 2'b01 || sel == 2'b10)));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Pulse MULTU for one edge, then wait (bounded) for done.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int busy_cnt, output int stall_cnt);
      bit seen;
      src_a = a; src_b = b; MULTU = 1'b1;
      tick();
      MULTU = 1'b0;
      busy_cnt = 0; stall_cnt = 0; seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (stall) stall_cnt++;
         if (done) seen = 1'b1;
      end
      vectors++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: got no done expected done within 100 cycles");
      end
   endtask

   initial begin
      int bc, sc;
      // Reset with MULTU held high.
      rst_n = 1'b0; MULTU = 1'b1; sel = 2'b00; alu_result = 32'hA5A5_0F0F;
      src_a = 32'h1234; src_b = 32'h5678;
      tick(); tick();
      @(negedge clk);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", W'(busy), 32'h0);
      chk("rst_done", W'(done), 32'h0);
      chk("rst_dataOut", dataOut, 32'hA5A5_0F0F);
      tick();
      rst_n = 1'b1; MULTU = 1'b0;
      tick();

      // Max operands, reading HI during the multiply.
      sel = 2'b01;
      run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, sc);
      chk("max_busy_cycles", W'(bc), W'(LAT));
      chk("max_stall_cycles", W'(sc), W'(LAT));
      chk("max_stall_in_done", W'(stall), 32'h0);
      chk("max_hi", hi, 32'hFFFF_FFFE);
      chk("max_lo", lo, 32'h0000_0001);
      chk("max_dataOut", dataOut, 32'hFFFF_FFFE);
      tick();

      // Zero operand, then small operands with sel=00 (no stall).
      sel = 2'b00;
      run_mul(32'h1234_5678, 32'h0, bc, sc);
      chk("zero_hi", hi, 32'h0);
      chk("zero_lo", lo, 32'h0);
      chk("sel00_stall_cycles", W'(sc), 32'h0);
      tick();
      sel = 2'b10;
      run_mul(32'd7, 32'd6, bc, sc);
      chk("small_hi", hi, 32'h0);
      chk("small_lo", lo, 32'h2A);
      tick();

      // Start request mid-RUN is ignored.
      sel = 2'b00;
      src_a = 32'd5; src_b = 32'd9; MULTU = 1'b1;
      tick();
      MULTU = 1'b0;
      repeat (4) tick();
      src_a = 32'd3; src_b = 32'd3; MULTU = 1'b1;
      repeat (3) tick();
      MULTU = 1'b0;
      repeat (LAT) tick();
      chk("ignored_lo", lo, 32'd45);
      chk("ignored_hi", hi, 32'd0);
      tick();

      // SLL path.
      sel = 2'b11; SLL = 1'b1; src_b = 32'h8000_0001; shamt = 5'd1;
      @(negedge clk);
      chk("sll_1", dataOut, 32'h0000_0002);
      tick();
      shamt = 5'd31;
      @(negedge clk);
      chk("sll_31", dataOut, 32'h8000_0000);
      tick();
      SLL = 1'b0;
      @(negedge clk);
      chk("sll_off", dataOut, 32'h0);
      tick();

      // Reset mid-RUN aborts the multiply and clears HI/LO.
      sel = 2'b10;
      src_a = 32'h0001_0000; src_b = 32'h0001_0000; MULTU = 1'b1;
      tick();
      MULTU = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_busy", W'(busy), 32'h0);
      chk("abort_hi", hi, 32'h0);
      chk("abort_lo", lo, 32'h0);
      repeat (LAT + 3) tick();
      @(negedge clk);
      chk("abort_no_done_lo", lo, 32'h0);
      tick();

      // Random traffic; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 499) != 0);
         MULTU      = ($urandom_range(0, 7) == 0);
         SLL        = $urandom_range(0, 1);
         sel        = 2'($urandom_range(0, 3));
         shamt      = 5'($urandom);
         alu_result = $urandom;
         case ($urandom_range(0, 3))
            0:       begin src_a = $urandom; src_b = $urandom; end
            1:       begin src_a = 32'hFFFF_FFFF; src_b = $urandom; end
            2:       begin src_a = $urandom_range(0, 15); src_b = $urandom_range(0, 15); end
            default: begin src_a = $urandom; src_b = 32'hFFFF_FFFF; end
         endcase
         tick();
      end
      rst_n = 1'b1; MULTU = 1'b0;
      repeat (LAT + 3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
